// File: rtl/segment_ring_spinner.sv
// segment_ring_spinner: ring animator for a circular group of display segments.
// A head position walks the ring at a programmable step period, either rotating
// with wrap-around or bouncing between the two ends, and can be paused with ena.
// Optional feature macro: SPINNER_TAIL_EN adds up to three lit trailing
// positions behind the head. Without it the tail_i port is ignored and ring_o
// is strictly one-hot at the head.
module segment_ring_spinner #(
  parameter int unsigned RING_LEN = 6,
  parameter int unsigned DIV_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic                        dir_i,
  input  logic                        mode_i,
  input  logic [DIV_W-1:0]            speed_i,
  input  logic [1:0]                  tail_i,
  output logic [RING_LEN-1:0]         ring_o,
  output logic [$clog2(RING_LEN)-1:0] pos_o,
  output logic                        step_o
);

  localparam int unsigned PW   = $clog2(RING_LEN);
  localparam logic [PW-1:0] LAST = PW'(RING_LEN - 1);

  typedef enum logic {
    FWD = 1'b0,
    REV = 1'b1
  } dir_t;

  logic [PW-1:0]    pos;
  logic [PW-1:0]    pos_inc;
  logic [PW-1:0]    pos_dec;
  logic [PW-1:0]    pos_nxt;
  logic [DIV_W-1:0] cnt;
  dir_t             bdir;
  dir_t             bdir_nxt;
  logic             step;

  // A step fires when the prescaler has reached (or been overtaken by) the period.
  assign step = ena && (cnt >= speed_i);

  // Neighbour positions with wrap-around at either end of the ring.
  assign pos_inc = (pos == LAST) ? '0 : pos + PW'(1);
  assign pos_dec = (pos == '0) ? LAST : pos - PW'(1);

  // Head position and bounce direction that a step would produce.
  always_comb begin
    pos_nxt  = pos;
    bdir_nxt = bdir;
    if (!mode_i) begin
      pos_nxt = dir_i ? pos_dec : pos_inc;
    end else if (bdir == FWD) begin
      if (pos == LAST) begin
        pos_nxt  = pos_dec;
        bdir_nxt = REV;
      end else begin
        pos_nxt = pos_inc;
      end
    end else begin
      if (pos == '0) begin
        pos_nxt  = pos_inc;
        bdir_nxt = FWD;
      end else begin
        pos_nxt = pos_dec;
      end
    end
  end

  // Prescaler, head, bounce direction and step pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos    <= '0;
      cnt    <= '0;
      bdir   <= FWD;
      step_o <= 1'b0;
    end else begin
      step_o <= step;
      if (ena) begin
        if (step) begin
          cnt <= '0;
          pos <= pos_nxt;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
        // Rotate mode keeps bdir tracking dir_i so bounce resumes the same way.
        if (!mode_i) begin
          bdir <= dir_t'(dir_i);
        end else if (step) begin
          bdir <= bdir_nxt;
        end
      end
    end
  end

  assign pos_o = pos;

`ifdef SPINNER_TAIL_EN

  localparam int unsigned MAX_TAIL = (RING_LEN - 1 > 3) ? 3 : RING_LEN - 1;
  localparam int          RL       = int'(RING_LEN);

  logic [1:0] tail_q;
  logic [1:0] tail_ld;
  logic       trav_rev;

  // Tail length cannot exceed the number of non-head positions.
  assign tail_ld = (32'(tail_i) > MAX_TAIL) ? 2'(MAX_TAIL) : tail_i;

  // Tail length only changes together with a head move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail_q <= '0;
    end else if (step) begin
      tail_q <= tail_ld;
    end
  end

  // The tail trails opposite the direction of travel.
  assign trav_rev = mode_i ? (bdir == REV) : dir_i;

  // Head plus tail decode; rotate wraps the tail, bounce clips it at the ends.
  always_comb begin
    int idx;
    idx         = 0;
    ring_o      = '0;
    ring_o[pos] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if (k <= int'(tail_q)) begin
        idx = trav_rev ? (int'(pos) + k) : (int'(pos) - k);
        if (!mode_i) begin
          if (idx < 0) begin
            idx = idx + RL;
          end else if (idx >= RL) begin
            idx = idx - RL;
          end
          ring_o[PW'(idx)] = 1'b1;
        end else if ((idx >= 0) && (idx < RL)) begin
          ring_o[PW'(idx)] = 1'b1;
        end
      end
    end
  end

`else

  logic unused_tail;

  // Tail input has no effect in this build.
  assign unused_tail = ^tail_i;

  // Strictly one-hot head decode.
  assign ring_o = RING_LEN'(1) << pos;

`endif

endmodule

// File: tb/tb_segment_ring_spinner.sv
// Directed bench for segment_ring_spinner (RING_LEN=6, DIV_W=8); tail
// expectations follow whether SPINNER_TAIL_EN is defined for the build.
module tb_segment_ring_spinner;

`ifdef SPINNER_TAIL_EN
  localparam bit TAIL = 1'b1;
`else
  localparam bit TAIL = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       dir_i;
  logic       mode_i;
  logic [7:0] speed_i;
  logic [1:0] tail_i;
  logic [5:0] ring_o;
  logic [2:0] pos_o;
  logic       step_o;

  int n_assert = 0;
  int n_fail   = 0;

  // reverse rotation with period 4
  int rev_pos[8]  = '{0, 0, 0, 5, 5, 5, 5, 4};
  int rev_step[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  // bounce sweep from position 0
  int bnc_pos[11] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
  // rotate forward with tail 2
  int rt_pos[5]   = '{2, 3, 4, 5, 0};
  int rt_ring[5]  = '{6'h07, 6'h0E, 6'h1C, 6'h38, 6'h31};
  // bounce with tail 2 through the top turn
  int bt_pos[7]   = '{1, 2, 3, 4, 5, 4, 3};
  int bt_ring[7]  = '{6'h03, 6'h07, 6'h0E, 6'h1C, 6'h38, 6'h30, 6'h38};

  segment_ring_spinner #(
    .RING_LEN(6),
    .DIV_W   (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .dir_i  (dir_i),
    .mode_i (mode_i),
    .speed_i(speed_i),
    .tail_i (tail_i),
    .ring_o (ring_o),
    .pos_o  (pos_o),
    .step_o (step_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input int p, input int s, input int r);
    check({tag, " pos"}, int'(pos_o), p);
    check({tag, " step"}, int'(step_o), s);
    check({tag, " ring"}, int'(ring_o), r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    ena     = 1'b0;
    dir_i   = 1'b0;
    mode_i  = 1'b0;
    speed_i = 8'd0;
    tail_i  = 2'd0;
    #12;
    expect_state("reset", 0, 0, 6'h01);

    // forward, one step per clock
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_state("fwd", (i + 1) % 6, 1, 1 << ((i + 1) % 6));
    end

    // reverse with a four-cycle period
    dir_i   = 1'b1;
    speed_i = 8'd3;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_state("rev", rev_pos[i], rev_step[i], 1 << rev_pos[i]);
    end

    // pause mid-count, then finish the remaining count
    tick();
    expect_state("pre_pause", 4, 0, 6'h10);
    tick();
    expect_state("pre_pause", 4, 0, 6'h10);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_state("pause", 4, 0, 6'h10);
    end
    ena = 1'b1;
    tick();
    expect_state("resume", 4, 0, 6'h10);
    tick();
    expect_state("resume", 3, 1, 6'h08);

    // walk back to position 0 at full speed
    speed_i = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state("to_zero", 2 - i, 1, 1 << (2 - i));
    end

    // bounce sweep; dir_i must be ignored
    mode_i = 1'b1;
    dir_i  = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      expect_state("bounce", bnc_pos[i], 1, 1 << bnc_pos[i]);
    end

    // rotate forward with a two-position tail, wrapping at the ends
    mode_i = 1'b0;
    tail_i = 2'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_state("rot_tail", rt_pos[i], 1, TAIL ? rt_ring[i] : (1 << rt_pos[i]));
    end

    // switching to bounce at the bottom clips the tail instead of wrapping
    mode_i = 1'b1;
    #1;
    check("bnc_clip ring", int'(ring_o), 6'h01);
    for (int i = 0; i < 7; i++) begin
      tick();
      expect_state("bnc_tail", bt_pos[i], 1, TAIL ? bt_ring[i] : (1 << bt_pos[i]));
    end

    // tail change takes effect only at the next head move
    speed_i = 8'd2;
    tail_i  = 2'd0;
    tick();
    expect_state("tail_hold", 3, 0, TAIL ? 6'h38 : 6'h08);
    tick();
    expect_state("tail_hold", 3, 0, TAIL ? 6'h38 : 6'h08);
    tick();
    expect_state("tail_load", 2, 1, 6'h04);

    // asynchronous reset between clock edges
    speed_i = 8'd0;
    tick();
    expect_state("pre_rst", 1, 1, 6'h02);
    #3;
    rst_n = 1'b0;
    #1;
    expect_state("mid_rst", 0, 0, 6'h01);

    // lowering the period below the running count forces a step
    @(negedge clk);
    rst_n   = 1'b1;
    mode_i  = 1'b0;
    dir_i   = 1'b0;
    speed_i = 8'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_state("slow", 0, 0, 6'h01);
    end
    speed_i = 8'd2;
    tick();
    expect_state("speed_drop", 1, 1, 6'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
